// File: rtl/move_sequencer.sv
// move_sequencer: turns held direction buttons into timed one-pixel player steps,
// checks each non-wrapping step against the map/collision memory before committing
// it, and handles screen-edge wrap with room index updates.
// Optional feature macro: MOVE_COLLISION_EN (collision query handshake).
// When it is undefined every tick expiry commits directly and col_req/col_x/col_y are 0.
`timescale 1ns/1ps

module move_sequencer #(
    parameter int TICK_MAX = 150000,
    parameter int X_MIN    = 144,
    parameter int X_MAX    = 784,
    parameter int Y_MIN    = 35,
    parameter int Y_MAX    = 515,
    parameter int SPRITE   = 16,
    parameter int X_INIT   = 455,
    parameter int Y_INIT   = 266
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       col_gnt,
    input  logic       col_valid,
    input  logic       col_wall,
    output logic       col_req,
    output logic [9:0] col_x,
    output logic [9:0] col_y,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] map_x,
    output logic [2:0] map_y,
    output logic       step,
    output logic       busy
);

    localparam int CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX - 1);
    localparam logic [9:0] X_LO   = 10'(X_MIN);
    localparam logic [9:0] X_HI   = 10'(X_MAX - SPRITE);
    localparam logic [9:0] Y_LO   = 10'(Y_MIN);
    localparam logic [9:0] Y_HI   = 10'(Y_MAX - SPRITE);
    localparam logic [9:0] X_RST  = 10'(X_INIT);
    localparam logic [9:0] Y_RST  = 10'(Y_INIT);

    typedef enum logic [1:0] {DIR_LEFT, DIR_DOWN, DIR_UP, DIR_RIGHT} dir_t;

`ifdef MOVE_COLLISION_EN
    typedef enum logic [2:0] {IDLE, WAIT_TICK, QUERY, WAIT_RESP, COMMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_TICK, COMMIT} state_t;
`endif

    // Button bit order inside the synchronizer: {left, down, up, right}
    logic [3:0]       btn_meta_reg, btn_sync_reg;
    state_t           state_reg, state_next;
    dir_t             dir_reg, dir_next, sel_dir;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [9:0]       cand_x_reg, cand_x_next, cand_y_reg, cand_y_next;
    logic [2:0]       cand_mx_reg, cand_mx_next, cand_my_reg, cand_my_next;
    logic [9:0]       x_pos_reg, x_pos_next, y_pos_reg, y_pos_next;
    logic [2:0]       map_x_reg, map_x_next, map_y_reg, map_y_next;
    logic             step_reg, step_next;
    logic             held;
    logic [9:0]       cand_x_c, cand_y_c;
    logic [2:0]       cand_mx_c, cand_my_c;
    logic             wrap_c;

    // Two-flop synchronizer, inverting the active-low buttons to active-high
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            btn_meta_reg <= 4'b0000;
            btn_sync_reg <= 4'b0000;
        end else begin
            btn_meta_reg <= ~{btn_left, btn_down, btn_up, btn_right};
            btn_sync_reg <= btn_meta_reg;
        end
    end

    // Priority pick of a new direction and "latched button still held" test
    always_comb begin
        sel_dir = DIR_RIGHT;
        if (btn_sync_reg[3])      sel_dir = DIR_LEFT;
        else if (btn_sync_reg[2]) sel_dir = DIR_DOWN;
        else if (btn_sync_reg[1]) sel_dir = DIR_UP;
        held = 1'b0;
        case (dir_reg)
            DIR_LEFT:  held = btn_sync_reg[3];
            DIR_DOWN:  held = btn_sync_reg[2];
            DIR_UP:    held = btn_sync_reg[1];
            DIR_RIGHT: held = btn_sync_reg[0];
            default:   held = 1'b0;
        endcase
    end

    // Candidate position one pixel along the latched direction, wrapping at the edges
    always_comb begin
        cand_x_c  = x_pos_reg;
        cand_y_c  = y_pos_reg;
        cand_mx_c = map_x_reg;
        cand_my_c = map_y_reg;
        wrap_c    = 1'b0;
        case (dir_reg)
            DIR_LEFT: begin
                if (x_pos_reg == X_LO) begin
                    cand_x_c  = X_HI;
                    cand_mx_c = map_x_reg - 3'd1;
                    wrap_c    = 1'b1;
                end else begin
                    cand_x_c = x_pos_reg - 10'd1;
                end
            end
            DIR_RIGHT: begin
                if (x_pos_reg == X_HI) begin
                    cand_x_c  = X_LO;
                    cand_mx_c = map_x_reg + 3'd1;
                    wrap_c    = 1'b1;
                end else begin
                    cand_x_c = x_pos_reg + 10'd1;
                end
            end
            DIR_UP: begin
                if (y_pos_reg == Y_LO) begin
                    cand_y_c  = Y_HI;
                    cand_my_c = map_y_reg - 3'd1;
                    wrap_c    = 1'b1;
                end else begin
                    cand_y_c = y_pos_reg - 10'd1;
                end
            end
            DIR_DOWN: begin
                if (y_pos_reg == Y_HI) begin
                    cand_y_c  = Y_LO;
                    cand_my_c = map_y_reg + 3'd1;
                    wrap_c    = 1'b1;
                end else begin
                    cand_y_c = y_pos_reg + 10'd1;
                end
            end
            default: wrap_c = 1'b0;
        endcase
    end

`ifdef MOVE_COLLISION_EN
    logic       col_req_reg, col_req_next;
    logic [9:0] col_x_reg, col_x_next, col_y_reg, col_y_next;

    assign col_req = col_req_reg;
    assign col_x   = col_x_reg;
    assign col_y   = col_y_reg;

    // Query interface registers; reset drops an in-flight request at once
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            col_req_reg <= 1'b0;
            col_x_reg   <= 10'd0;
            col_y_reg   <= 10'd0;
        end else begin
            col_req_reg <= col_req_next;
            col_x_reg   <= col_x_next;
            col_y_reg   <= col_y_next;
        end
    end
`else
    logic unused_coll_inputs;

    assign col_req = 1'b0;
    assign col_x   = 10'd0;
    assign col_y   = 10'd0;
    assign unused_coll_inputs = &{1'b0, col_gnt, col_valid, col_wall, wrap_c};
`endif

    // State, counter, candidate and committed position registers
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            dir_reg     <= DIR_LEFT;
            cnt_reg     <= '0;
            cand_x_reg  <= X_RST;
            cand_y_reg  <= Y_RST;
            cand_mx_reg <= 3'd1;
            cand_my_reg <= 3'd1;
            x_pos_reg   <= X_RST;
            y_pos_reg   <= Y_RST;
            map_x_reg   <= 3'd1;
            map_y_reg   <= 3'd1;
            step_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            cnt_reg     <= cnt_next;
            cand_x_reg  <= cand_x_next;
            cand_y_reg  <= cand_y_next;
            cand_mx_reg <= cand_mx_next;
            cand_my_reg <= cand_my_next;
            x_pos_reg   <= x_pos_next;
            y_pos_reg   <= y_pos_next;
            map_x_reg   <= map_x_next;
            map_y_reg   <= map_y_next;
            step_reg    <= step_next;
        end
    end

    // Next-state logic: tick timing, optional collision handshake, commit
    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        cnt_next     = cnt_reg;
        cand_x_next  = cand_x_reg;
        cand_y_next  = cand_y_reg;
        cand_mx_next = cand_mx_reg;
        cand_my_next = cand_my_reg;
        x_pos_next   = x_pos_reg;
        y_pos_next   = y_pos_reg;
        map_x_next   = map_x_reg;
        map_y_next   = map_y_reg;
        step_next    = 1'b0;
`ifdef MOVE_COLLISION_EN
        col_req_next = col_req_reg;
        col_x_next   = col_x_reg;
        col_y_next   = col_y_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|btn_sync_reg) begin
                    dir_next   = sel_dir;
                    cnt_next   = '0;
                    state_next = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!held) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    cand_x_next  = cand_x_c;
                    cand_y_next  = cand_y_c;
                    cand_mx_next = cand_mx_c;
                    cand_my_next = cand_my_c;
`ifdef MOVE_COLLISION_EN
                    if (wrap_c) begin
                        state_next = COMMIT;
                    end else begin
                        col_req_next = 1'b1;
                        col_x_next   = cand_x_c;
                        col_y_next   = cand_y_c;
                        state_next   = QUERY;
                    end
`else
                    state_next = COMMIT;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef MOVE_COLLISION_EN
            QUERY: begin
                if (col_gnt) begin
                    col_req_next = 1'b0;
                    // A response in the grant cycle is resolved right away
                    if (col_valid) begin
                        if (!col_wall) begin
                            state_next = COMMIT;
                        end else begin
                            cnt_next   = '0;
                            state_next = held ? WAIT_TICK : IDLE;
                        end
                    end else begin
                        state_next = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (col_valid) begin
                    if (!col_wall) begin
                        state_next = COMMIT;
                    end else begin
                        cnt_next   = '0;
                        state_next = held ? WAIT_TICK : IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                x_pos_next = cand_x_reg;
                y_pos_next = cand_y_reg;
                map_x_next = cand_mx_reg;
                map_y_next = cand_my_reg;
                step_next  = 1'b1;
                cnt_next   = '0;
                state_next = held ? WAIT_TICK : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign x_pos = x_pos_reg;
    assign y_pos = y_pos_reg;
    assign map_x = map_x_reg;
    assign map_y = map_y_reg;
    assign step  = step_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a stimulus planner computes the expected
// query coordinates and committed positions from the movement rules, a bench-side
// arbiter answers queries from a random wall schedule, and a monitor compares.
`timescale 1ns/1ps

module tb_move_sequencer;

    localparam int TICK   = 8;
    localparam int X_MIN  = 144;
    localparam int X_MAX  = 784;
    localparam int Y_MIN  = 35;
    localparam int Y_MAX  = 515;
    localparam int SPRITE = 16;
    localparam int X_INIT = 455;
    localparam int Y_INIT = 266;
`ifdef MOVE_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic       CLOCK_25 = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
    logic       col_gnt = 1'b0, col_valid = 1'b0, col_wall = 1'b0;
    logic       col_req, step, busy;
    logic [9:0] col_x, col_y, x_pos, y_pos;
    logic [2:0] map_x, map_y;

    typedef struct {int x; int y; int mx; int my;} pos_t;
    typedef struct {int x; int y;} qry_t;

    pos_t commit_q[$];
    qry_t query_q[$];
    bit   wall_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   commits_seen = 0;
    int   m_x = X_INIT, m_y = Y_INIT, m_mx = 1, m_my = 1;
    bit   auto_arb = 1'b1;

    move_sequencer #(.TICK_MAX(TICK)) dut (
        .CLOCK_25(CLOCK_25), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .col_gnt(col_gnt), .col_valid(col_valid), .col_wall(col_wall),
        .col_req(col_req), .col_x(col_x), .col_y(col_y),
        .x_pos(x_pos), .y_pos(y_pos), .map_x(map_x), .map_y(map_y),
        .step(step), .busy(busy)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
    endtask

    // mask bits: {left, down, up, right}, 1 = pressed
    task automatic set_buttons(input logic [3:0] mask);
        btn_left  = ~mask[3];
        btn_down  = ~mask[2];
        btn_up    = ~mask[1];
        btn_right = ~mask[0];
    endtask

    // Expected behaviour of holding 'mask' until n positions have been committed
    task automatic plan_segment(input logic [3:0] mask, input int n);
        int dir, c, nx, ny, nmx, nmy;
        bit wrap, wall;
        dir = mask[3] ? 0 : mask[2] ? 1 : mask[1] ? 2 : 3;
        c = 0;
        while (c < n) begin
            nx = m_x; ny = m_y; nmx = m_mx; nmy = m_my; wrap = 1'b0;
            case (dir)
                0: if (m_x == X_MIN) begin nx = X_MAX - SPRITE; nmx = (m_mx + 7) % 8; wrap = 1'b1; end
                   else nx = m_x - 1;
                1: if (m_y == Y_MAX - SPRITE) begin ny = Y_MIN; nmy = (m_my + 1) % 8; wrap = 1'b1; end
                   else ny = m_y + 1;
                2: if (m_y == Y_MIN) begin ny = Y_MAX - SPRITE; nmy = (m_my + 7) % 8; wrap = 1'b1; end
                   else ny = m_y - 1;
                default: if (m_x == X_MAX - SPRITE) begin nx = X_MIN; nmx = (m_mx + 1) % 8; wrap = 1'b1; end
                   else nx = m_x + 1;
            endcase
            wall = 1'b0;
            if (COLL && !wrap) begin
                query_q.push_back(qry_t'{nx, ny});
                wall = ($urandom_range(0, 3) == 0);
                wall_q.push_back(wall);
            end
            if (!wall) begin
                commit_q.push_back(pos_t'{nx, ny, nmx, nmy});
                m_x = nx; m_y = ny; m_mx = nmx; m_my = nmy;
                c++;
            end
        end
    endtask

    task automatic check_position(input string tag);
        check({tag, "_x_pos"}, x_pos, m_x);
        check({tag, "_y_pos"}, y_pos, m_y);
        check({tag, "_map_x"}, map_x, m_mx);
        check({tag, "_map_y"}, map_y, m_my);
    endtask

    task automatic run_segment(input logic [3:0] mask, input int n);
        int target, budget;
        target = commits_seen + n;
        plan_segment(mask, n);
        set_buttons(mask);
        budget = n * 60 + 200;
        while (commits_seen < target && budget > 0) begin
            tick();
            budget--;
        end
        set_buttons(4'b0000);
        check("segment_commits", commits_seen, target);
        repeat (12) tick();
        check("segment_idle_busy", busy, 0);
        check_position("segment");
        check("query_q_drained", query_q.size(), 0);
        check("commit_q_drained", commit_q.size(), 0);
        query_q.delete();
        commit_q.delete();
        wall_q.delete();
    endtask

    // Bench-side arbiter: random grant delay, random response delay (0 = with grant)
    initial begin
        int d, v;
        bit w;
        forever begin
            tick();
            if (auto_arb && col_req && !reset) begin
                d = $urandom_range(0, 2);
                repeat (d) tick();
                w = (wall_q.size() > 0) ? wall_q.pop_front() : 1'b0;
                v = $urandom_range(0, 2);
                col_gnt = 1'b1;
                if (v == 0) begin
                    col_valid = 1'b1;
                    col_wall  = w;
                end
                tick();
                col_gnt = 1'b0;
                col_valid = 1'b0;
                if (v != 0) begin
                    repeat (v - 1) tick();
                    col_valid = 1'b1;
                    col_wall  = w;
                    tick();
                    col_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every granted query and every step pulse against the queues
    always @(negedge CLOCK_25) begin
        if (!reset) begin
            if (col_req && col_gnt) begin
                if (query_q.size() == 0) begin
                    check("unexpected_query", 1, 0);
                end else begin
                    qry_t q;
                    q = query_q.pop_front();
                    check("query_col_x", col_x, q.x);
                    check("query_col_y", col_y, q.y);
                end
            end
            if (step) begin
                commits_seen++;
                if (commit_q.size() == 0) begin
                    check("unexpected_step", 1, 0);
                end else begin
                    pos_t p;
                    p = commit_q.pop_front();
                    $display("step %0d: x=%0d y=%0d map=(%0d,%0d) expected x=%0d y=%0d map=(%0d,%0d)",
                             commits_seen, x_pos, y_pos, map_x, map_y, p.x, p.y, p.mx, p.my);
                    check("step_x_pos", x_pos, p.x);
                    check("step_y_pos", y_pos, p.y);
                    check("step_map_x", map_x, p.mx);
                    check("step_map_y", map_y, p.my);
                end
            end
        end
    end

    initial begin
        int budget;
        repeat (3) tick();
        check("reset_col_req", col_req, 0);
        reset = 1'b0;
        tick();
        check_position("reset");
        check("reset_busy", busy, 0);
        check("reset_step", step, 0);
        check("reset_col_x", col_x, 0);
        check("reset_col_y", col_y, 0);

`ifdef MOVE_COLLISION_EN
        // Left+down together: left wins; release while waiting for the response
        auto_arb = 1'b0;
        query_q.push_back(qry_t'{X_INIT - 1, Y_INIT});
        commit_q.push_back(pos_t'{X_INIT - 1, Y_INIT, 1, 1});
        m_x = X_INIT - 1;
        set_buttons(4'b1100);
        budget = 100;
        while (!col_req && budget > 0) begin tick(); budget--; end
        check("prio_req_seen", col_req, 1);
        repeat (2) tick();
        col_gnt = 1'b1;
        tick();
        col_gnt = 1'b0;
        set_buttons(4'b0000);
        repeat (4) tick();
        check("wait_resp_busy", busy, 1);
        check("wait_resp_req_low", col_req, 0);
        col_valid = 1'b1;
        col_wall = 1'b0;
        tick();
        col_valid = 1'b0;
        repeat (8) tick();
        check("release_commit_busy", busy, 0);
        check_position("release_commit");
        check("release_commit_q", commit_q.size(), 0);
        auto_arb = 1'b1;
`else
        run_segment(4'b1100, 1);
`endif

        for (int i = 0; i < 8; i++) begin
            run_segment(4'($urandom_range(1, 15)), $urandom_range(1, 4));
        end
        run_segment(4'b1000, (m_x - X_MIN) + 1);
        run_segment(4'b1000, (X_MAX - SPRITE - X_MIN) + 1);
        run_segment(4'b0010, (m_y - Y_MIN) + 1);
        run_segment(4'b0100, 3);
        run_segment(4'b0001, 3);

        // Reset in the middle of a move
        auto_arb = 1'b0;
        set_buttons(4'b0001);
`ifdef MOVE_COLLISION_EN
        budget = 100;
        while (!col_req && budget > 0) begin tick(); budget--; end
        check("midreset_req_seen", col_req, 1);
`else
        repeat (5) tick();
        check("midreset_busy_before", busy, 1);
`endif
        reset = 1'b1;
        #1;
        m_x = X_INIT; m_y = Y_INIT; m_mx = 1; m_my = 1;
        check("midreset_col_req", col_req, 0);
        check("midreset_busy", busy, 0);
        check("midreset_col_x", col_x, 0);
        check_position("midreset");
        set_buttons(4'b0000);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        col_valid = 1'b1;
        col_wall = 1'b0;
        tick();
        col_valid = 1'b0;
        repeat (8) tick();
        check("late_valid_busy", busy, 0);
        check_position("late_valid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Controller that sequences player movement in the maze game. It turns held direction buttons into timed single-pixel steps, asks the shared map/collision memory about each step before committing it, and handles screen-edge wrap with map-room coordinate updates. It owns the player position registers (x/y in VGA timing coordinates) and the room indices that the renderer consumes.

Parameters:
TICK_MAX, 150000, clock cycles between consecutive steps while a direction is held
X_MIN, 144, leftmost sprite x (start of active video)
X_MAX, 784, end of active video in x (exclusive)
Y_MIN, 35, topmost sprite y
Y_MAX, 515, end of active video in y (exclusive)
SPRITE, 16, sprite edge length in pixels
X_INIT, 455, x position after reset
Y_INIT, 266, y position after reset

Ports:
CLOCK_25  in  1  system clock, 25 MHz
reset  in  1  asynchronous, active-high
btn_up / btn_down / btn_left / btn_right  in  1 each  raw buttons, active-low, asynchronous
col_gnt  in  1  one-cycle grant from the map-memory arbiter
col_valid  in  1  one-cycle response strobe
col_wall  in  1  response: 1 = target occupied by wall (sampled when col_valid=1)
col_req  out  1  collision query request, held until col_gnt
col_x  out  10  queried candidate x, stable while col_req=1
col_y  out  10  queried candidate y, stable while col_req=1
x_pos  out  10  committed sprite x
y_pos  out  10  committed sprite y
map_x  out  3  room column index
map_y  out  3  room row index
step  out  1  one-cycle pulse on every committed position change
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: x_pos=X_INIT, y_pos=Y_INIT, map_x=1, map_y=1, col_req=0, col_x=0, col_y=0, step=0, busy=0, state IDLE, tick counter 0. Reset mid-transaction drops col_req immediately; any late col_valid is ignored.
- Buttons pass through a 2-flop synchronizer (2-cycle latency) and are inverted to active-high. Direction priority: left > down > up > right. The direction is latched on leaving IDLE and held until the state machine returns to IDLE.
- States: IDLE, WAIT_TICK, QUERY, WAIT_RESP, COMMIT.
- IDLE: when any synchronized button is high, latch the direction, clear the counter, and go to WAIT_TICK.
- WAIT_TICK: increment the counter each cycle while the latched button is held. If the button is released, go to IDLE and clear the counter. When the counter reaches TICK_MAX-1, compute the candidate position:
  - left: x-1; right: x+1; up: y-1; down: y+1.
  - If the move would wrap, go to COMMIT directly with no query.
  - Otherwise drive col_x/col_y with the candidate, set col_req=1, and go to QUERY.
- Wrap rules (for COMMIT):
  - left at x=X_MIN: x becomes X_MAX-SPRITE, map_x-1.
  - right at x=X_MAX-SPRITE: x becomes X_MIN, map_x+1.
  - up at y=Y_MIN: y becomes Y_MAX-SPRITE, map_y-1.
  - down at y=Y_MAX-SPRITE: y becomes Y_MIN, map_y+1.
  - map indices wrap modulo 8 (0-1=7, 7+1=0).
- QUERY: hold col_req and the coordinates. On the cycle col_gnt=1, deassert col_req on the next edge and go to WAIT_RESP. col_valid arriving in the same cycle as col_gnt is accepted.
- WAIT_RESP: wait for col_valid with no timeout.
  - col_wall=0: go to COMMIT.
  - col_wall=1: discard the candidate, clear the counter, return to WAIT_TICK (or IDLE if the button is released).
- Releasing the button during QUERY or WAIT_RESP does not abort the transaction. The query completes, a free result still commits, and the machine then returns to IDLE.
- COMMIT: update x_pos/y_pos (and map_x/map_y if wrapping) on this edge, pulse step for exactly one cycle, clear the counter, then go to WAIT_TICK if the button is still held, else IDLE. Latency from tick expiry to step is 1 cycle for a wrap; for a free query it is 1 cycle after col_valid.
- Arithmetic is 10-bit unsigned. The candidate never leaves [X_MIN, X_MAX-SPRITE] × [Y_MIN, Y_MAX-SPRITE] because boundary cases always take the wrap path.

Optional Feature:
MOVE_COLLISION_EN
- Defined: QUERY/WAIT_RESP are used as above.
- Undefined: the QUERY and WAIT_RESP states are removed, col_req is tied to 0, col_x/col_y are tied to 0, and every tick expiry goes straight to COMMIT. col_gnt/col_valid/col_wall stay as ports and are ignored.

Test Plan:
- Reset with defaults, no buttons -> x_pos=455, y_pos=266, map_x=1, map_y=1, busy=0, col_req=0.
- TICK_MAX=4, hold btn_right low, arbiter grants 1 cycle after req and returns col_valid=1/col_wall=0 the next cycle -> col_x=456, col_y=266; x_pos becomes 456 with a single step pulse; steps repeat while held.
- TICK_MAX=4, hold btn_up, response col_wall=1 -> y_pos stays 266, no step, col_req is reasserted after the next tick.
- Force x=144, hold btn_left (TICK_MAX=4) -> no col_req; x_pos=768, map_x=0 one cycle after tick expiry. Repeat from map_x=0 -> map_x=7.
- Press left and down simultaneously -> left wins (col_x=454). Release the button during WAIT_RESP, free result -> x commits to 454, then IDLE, busy=0.
- Assert reset while col_req=1 -> col_req=0 immediately; all outputs return to reset values; a col_valid arriving afterwards does not change position.
